// File: rtl/urv_irq_source.sv
// -----------------------------------------------------------------------------
// urv_irq_source
//
// Interrupt and tick source feeding the core's exception unit. It holds:
//   - a programmable periodic down-counter that emits single-cycle ticks
//   - an N-line external interrupt aggregator with rising-edge capture,
//     per-line enable, a pending register and a claim register
//   - a word-addressed register port on the data bus
//
// Optional build feature (compile-time macro):
//   URV_IRQ_SYNC_EN - when defined, every irq_lines_i bit passes through a
//                     2-flop synchronizer before edge detection, so the lines
//                     may come from asynchronous sources. This adds 2 cycles
//                     of latency to PENDING and exp_irq_o.
//
// Register map (reg_addr_i, word index):
//   0 RELOAD  rw   timer reload value (writing also loads COUNT)
//   1 COUNT   ro   current timer count
//   2 CTRL    rw   bit0 = timer enable
//   3 PENDING r/w1c captured edges
//   4 ENABLE  rw   per-line enable
//   5 CLAIM   ro   lowest enabled pending line + 1 (0 if none); clears it
//   6-7            read 0, writes ignored
//
// Ports:
//   clk_i        system clock
//   rst_i        synchronous reset, active-high
//   irq_lines_i  external interrupt lines, rising-edge significant
//   reg_addr_i   register word index
//   reg_wdata_i  write data
//   reg_we_i     write strobe (single cycle)
//   reg_re_i     read strobe (single cycle)
//   reg_rdata_o  read data, valid while reg_ack_o=1, 0 otherwise
//   reg_ack_o    access acknowledge
//   exp_tick_o   timer tick pulse (1 cycle)
//   exp_irq_o    level interrupt request
//
// Bus handshake: a strobe (reg_we_i and/or reg_re_i) is accepted in the cycle
// it is high -- there is no back-pressure. reg_ack_o is high exactly one cycle
// later, and reg_rdata_o carries the registered read value in that same cycle.
// When both strobes are high together the write is performed, the read returns
// the pre-write value, and the read has no side effects.
// -----------------------------------------------------------------------------
module urv_irq_source #(
  parameter int G_NUM_IRQS    = 8,
  parameter int G_TIMER_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [G_NUM_IRQS-1:0] irq_lines_i,
  input  logic [2:0]            reg_addr_i,
  input  logic [31:0]           reg_wdata_i,
  input  logic                  reg_we_i,
  input  logic                  reg_re_i,
  output logic [31:0]           reg_rdata_o,
  output logic                  reg_ack_o,
  output logic                  exp_tick_o,
  output logic                  exp_irq_o
);

  localparam logic [2:0] A_RELOAD  = 3'd0;
  localparam logic [2:0] A_COUNT   = 3'd1;
  localparam logic [2:0] A_CTRL    = 3'd2;
  localparam logic [2:0] A_PENDING = 3'd3;
  localparam logic [2:0] A_ENABLE  = 3'd4;
  localparam logic [2:0] A_CLAIM   = 3'd5;

  logic [G_TIMER_WIDTH-1:0] r_reload;
  logic [G_TIMER_WIDTH-1:0] r_count;
  logic                     r_ctrl_en;
  logic [G_NUM_IRQS-1:0]    r_pending;
  logic [G_NUM_IRQS-1:0]    r_enable;
  logic [G_NUM_IRQS-1:0]    r_prev;
  logic [31:0]              r_rdata;
  logic                     r_ack;
  logic                     r_tick;
  logic                     r_irq;

  logic [G_NUM_IRQS-1:0]    w_lines;
  logic [G_NUM_IRQS-1:0]    w_edge;
  logic [G_NUM_IRQS-1:0]    w_active;
  logic [G_NUM_IRQS-1:0]    w_claim_mask;
  logic [G_NUM_IRQS-1:0]    w_clear;
  logic [31:0]              w_claim_val;
  logic [31:0]              w_rmux;
  logic                     w_wr_reload;
  logic                     w_wr_ctrl;
  logic                     w_wr_pending;
  logic                     w_wr_enable;
  logic                     w_claim_rd;
  logic                     w_unused;

  // Upper write-data bits beyond the register widths are intentionally dropped.
  assign w_unused = ^reg_wdata_i;

  // ---------------------------------------------------------------------------
  // Line sampling (optionally synchronized)
  // ---------------------------------------------------------------------------
`ifdef URV_IRQ_SYNC_EN
  logic [G_NUM_IRQS-1:0] r_sync1;
  logic [G_NUM_IRQS-1:0] r_sync2;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= irq_lines_i;
      r_sync2 <= r_sync1;
    end
  end

  assign w_lines = r_sync2;
`else
  assign w_lines = irq_lines_i;
`endif

  assign w_edge   = w_lines & ~r_prev;
  assign w_active = r_pending & r_enable;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  assign w_wr_reload  = reg_we_i && (reg_addr_i == A_RELOAD);
  assign w_wr_ctrl    = reg_we_i && (reg_addr_i == A_CTRL);
  assign w_wr_pending = reg_we_i && (reg_addr_i == A_PENDING);
  assign w_wr_enable  = reg_we_i && (reg_addr_i == A_ENABLE);
  // A simultaneous write suppresses the read side effect.
  assign w_claim_rd   = reg_re_i && !reg_we_i && (reg_addr_i == A_CLAIM);

  // Lowest-index enabled pending line; scanning high to low lets the lowest
  // index overwrite the result last.
  always_comb begin
    w_claim_val  = '0;
    w_claim_mask = '0;
    for (int k = G_NUM_IRQS - 1; k >= 0; k--) begin
      if (w_active[k]) begin
        w_claim_val     = 32'(k + 1);
        w_claim_mask    = '0;
        w_claim_mask[k] = 1'b1;
      end
    end
  end

  always_comb begin
    w_clear = '0;
    if (w_wr_pending) w_clear = w_clear | reg_wdata_i[G_NUM_IRQS-1:0];
    if (w_claim_rd)   w_clear = w_clear | w_claim_mask;
  end

  always_comb begin
    w_rmux = '0;
    case (reg_addr_i)
      A_RELOAD:  w_rmux = 32'(r_reload);
      A_COUNT:   w_rmux = 32'(r_count);
      A_CTRL:    w_rmux = {31'd0, r_ctrl_en};
      A_PENDING: w_rmux = 32'(r_pending);
      A_ENABLE:  w_rmux = 32'(r_enable);
      A_CLAIM:   w_rmux = w_claim_val;
      default:   w_rmux = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_reload  <= '0;
      r_count   <= '0;
      r_ctrl_en <= 1'b0;
      r_pending <= '0;
      r_enable  <= '0;
      r_prev    <= '0;
      r_rdata   <= '0;
      r_ack     <= 1'b0;
      r_tick    <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_prev <= w_lines;

      // Bus response
      r_ack   <= reg_we_i || reg_re_i;
      r_rdata <= reg_re_i ? w_rmux : '0;

      if (w_wr_reload) r_reload  <= reg_wdata_i[G_TIMER_WIDTH-1:0];
      if (w_wr_ctrl)   r_ctrl_en <= reg_wdata_i[0];
      if (w_wr_enable) r_enable  <= reg_wdata_i[G_NUM_IRQS-1:0];

      // Timer: a RELOAD write loads COUNT and masks this edge's tick.
      if (w_wr_reload) begin
        r_count <= reg_wdata_i[G_TIMER_WIDTH-1:0];
        r_tick  <= 1'b0;
      end else if (r_ctrl_en) begin
        if (r_count == '0) begin
          r_count <= r_reload;
          r_tick  <= 1'b1;
        end else begin
          r_count <= r_count - G_TIMER_WIDTH'(1);
          r_tick  <= 1'b0;
        end
      end else begin
        r_tick <= 1'b0;
      end

      // Set wins over a same-cycle clear.
      r_pending <= (r_pending & ~w_clear) | w_edge;

      r_irq <= |w_active;
    end
  end

  assign reg_rdata_o = r_rdata;
  assign reg_ack_o   = r_ack;
  assign exp_tick_o  = r_tick;
  assign exp_irq_o   = r_irq;

endmodule

// File: doc/urv_irq_source.md
Name: urv_irq_source

Overview:
- Interrupt/tick generator on the producing side of the core's exception unit; drives its timer-tick and external-IRQ inputs.
- Contains a programmable periodic timer that emits single-cycle tick pulses.
- Contains an N-line external interrupt aggregator with edge capture, per-line enable, pending register and a claim register.
- Software configures it through a simple word-addressed register port on the data bus.

Parameters:
G_NUM_IRQS, 8, number of external interrupt lines (1..31)
G_TIMER_WIDTH, 32, width of the timer reload/count registers (1..32)

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous reset, active-high
irq_lines_i  in  G_NUM_IRQS  external interrupt request lines, active-high, rising-edge significant
reg_addr_i  in  3  register word index
reg_wdata_i  in  32  write data
reg_we_i  in  1  write strobe, single cycle
reg_re_i  in  1  read strobe, single cycle
reg_rdata_o  out  32  read data, valid when reg_ack_o=1
reg_ack_o  out  1  access acknowledge
exp_tick_o  out  1  timer tick pulse, 1 cycle wide, to the exception unit
exp_irq_o  out  1  level interrupt request to the exception unit

Behaviour:
- Reset (rst_i=1 at posedge): all registers 0, edge-detect history 0; all outputs 0 the cycle after reset.
- Register map (reg_addr_i):
  - 0 RELOAD (rw)
  - 1 COUNT (ro)
  - 2 CTRL (rw; bit0 = timer enable)
  - 3 PENDING (r; write-1-to-clear)
  - 4 ENABLE (rw)
  - 5 CLAIM (ro, side effect)
  - 6-7 read 0, writes ignored.
  - Registers narrower than 32 bits are zero-extended on read; upper bits are ignored on write.
- Bus timing:
  - reg_ack_o is asserted exactly 1 cycle after any strobe; reg_rdata_o is registered and valid in that cycle, and 0 otherwise.
  - Write and read strobes in the same cycle: the write is performed, the read returns the pre-write value, and no read side effects occur.
- Timer:
  - Down-counter COUNT.
  - When CTRL[0]=1:
    - If COUNT==0: next cycle COUNT=RELOAD and exp_tick_o=1 for one cycle.
    - Otherwise COUNT decrements by 1.
    - Tick period is RELOAD+1 cycles; RELOAD=0 gives a tick every cycle.
  - When CTRL[0]=0: COUNT holds and exp_tick_o=0.
  - Writing RELOAD also loads COUNT with the written value on the same edge, which overrides the decrement that cycle; no tick is generated by that edge.
- Edge capture:
  - Per line, a rising edge is prev==0 and cur==1, where prev is the registered previous sample.
  - A detected edge sets PENDING[i] on the next edge regardless of ENABLE.
  - A level held high causes no re-trigger.
- Pending clear:
  - W1C write to PENDING clears the bits written as 1.
  - A CLAIM read clears the claimed bit.
  - A set and a clear of the same bit in the same cycle: set wins.
- CLAIM read:
  - Returns k+1, where k is the lowest index with PENDING[k] & ENABLE[k]; returns 0 if none.
  - The returned bit is cleared at the ack edge.
- exp_irq_o is registered: exp_irq_o = |(PENDING & ENABLE) sampled one cycle earlier, so latency from irq_lines_i rising to exp_irq_o=1 is 2 cycles. It is level and stays high while any enabled line is pending.
- Disabling a line via ENABLE masks it from exp_irq_o and CLAIM but keeps its PENDING bit.
- Reset asserted mid-access: ack and any pending read are dropped, and the register file is reset.

Optional Feature:
URV_IRQ_SYNC_EN
- Defined: each irq_lines_i bit passes through a 2-flop synchronizer before edge detection, for asynchronous sources. Latency from line rising to PENDING set grows by 2 cycles, and to exp_irq_o becomes 4 cycles. Synchronizer flops reset to 0.
- Undefined: lines are sampled directly, as in Behaviour; inputs must be synchronous to clk_i.

Test Plan:
- Timer period: write RELOAD=3, CTRL=1 → exp_tick_o pulses every 4 cycles, each 1 cycle wide; write CTRL=0 → no further ticks, COUNT frozen.
- Edge capture and irq: ENABLE=0x05; pulse irq_lines_i[2] high for 1 cycle → exp_irq_o=1 two cycles later; PENDING reads 0x04; pulse line 1 → PENDING=0x06, exp_irq_o stays 1.
- Claim priority: PENDING=0x06, ENABLE=0x06 → CLAIM reads 2, then 3, then 0; exp_irq_o drops 1 cycle after the second claim's ack.
- Set-wins collision: W1C PENDING=0x01 on the same cycle as a rising edge on line 0 → PENDING[0] remains 1.
- Masking: line 3 pending, ENABLE=0 → exp_irq_o=0, CLAIM=0, PENDING=0x08; then set ENABLE=0x08 → exp_irq_o=1 one cycle later.
- Reset mid-operation: rst_i pulsed while timer running and PENDING=0xFF → all registers 0, exp_irq_o=0, exp_tick_o=0, reg_ack_o=0 the next cycle.
